// File: rtl/mmult3x3_seq_pkg.sv
// mmult_pkg: shared constants, FSM state type and packed-matrix index helper
package mmult_pkg;
  localparam int N = 3;
  localparam int DW = 18;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;
  function automatic int idx(input int i, input int j, input int dw);
    return ((i * 3) + j) * dw;
  endfunction
endpackage

// File: rtl/mmult3x3_seq_if.sv
// mmult3x3_seq_if: operand/result handshake bundle for the sequenced 3x3 multiplier
interface mmult3x3_seq_if #(parameter int DW = mmult_pkg::DW);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [9*DW-1:0] ai, bi, co;
  modport master (output in_valid, ai, bi, out_ready, input in_ready, out_valid, co, busy);
  modport slave (input in_valid, ai, bi, out_ready, output in_ready, out_valid, co, busy);
endinterface

// File: rtl/mmult3x3_seq_mac.sv
// mmult_mac: shared multiplier + accumulator; MMULT3X3_SEQ_PIPE_EN adds a product register
module mmult_mac #(parameter int DW = mmult_pkg::DW) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          clr,
  input  logic          last,
  output logic [DW-1:0] sum,
  output logic          sum_valid
);
  logic [2*DW-1:0] prod;
  logic [DW-1:0] acc_q, acc_d, add_in;
  logic add_last, unused_hi;
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign unused_hi = ^prod[2*DW-1:DW];
`ifdef MMULT3X3_SEQ_PIPE_EN
  logic [DW-1:0] prod_q, prod_d;
  logic last_q, last_d;
  // product stage: the adder works on the previous cycle's product
  always_comb begin
    prod_d = clr ? '0 : prod[DW-1:0];
    last_d = clr ? 1'b0 : last;
  end
  // product pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      last_q <= 1'b0;
    end else begin
      prod_q <= prod_d;
      last_q <= last_d;
    end
  end
  assign add_in = prod_q;
  assign add_last = last_q;
`else
  assign add_in = prod[DW-1:0];
  assign add_last = last;
`endif
  assign sum = acc_q + add_in;
  assign sum_valid = add_last;
  // accumulate modulo 2^DW; restart after each finished dot product
  always_comb acc_d = (clr || add_last) ? '0 : sum;
  // accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/mmult3x3_seq.sv
// mmult3x3_seq: C = A*B with one shared MAC; optional MMULT3X3_SEQ_PIPE_EN pipelines the multiplier
module mmult3x3_seq #(
  parameter int DW = mmult_pkg::DW,
  parameter int N = mmult_pkg::N
) (
  input logic clk,
  input logic rst_n,
  mmult3x3_seq_if.slave bus
);
  import mmult_pkg::*;
  if (N != 3) begin : g_n_check
    $error("mmult3x3_seq: N must be 3");
  end
  state_e state_q, state_d;
  logic [1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [3:0] e_q, e_d;
  logic drain_q, drain_d;
  logic [9*DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic accept, issue, last, sum_valid;
  logic [DW-1:0] op_a, op_b, sum;
  assign accept = state_q == IDLE && bus.in_valid;
  assign issue = state_q == MAC && !drain_q;
  assign last = issue && k_q == 2'd2;
  assign op_a = issue ? a_q[idx(int'(i_q), int'(k_q), DW) +: DW] : '0;
  assign op_b = issue ? b_q[idx(int'(k_q), int'(j_q), DW) +: DW] : '0;
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.co = c_q;
  mmult_mac #(.DW(DW)) u_mac (
    .clk(clk), .rst_n(rst_n), .a(op_a), .b(op_b), .clr(accept), .last(last),
    .sum(sum), .sum_valid(sum_valid)
  );
  // next state: operand capture, i/j/k walk (k innermost), C write-back in result order
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    e_d = e_q;
    drain_d = drain_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (accept) begin
      a_d = bus.ai;
      b_d = bus.bi;
      i_d = '0;
      j_d = '0;
      k_d = '0;
      e_d = '0;
      drain_d = 1'b0;
      state_d = MAC;
    end
    if (issue) begin
      k_d = k_q == 2'd2 ? 2'd0 : k_q + 2'd1;
      j_d = k_q == 2'd2 ? (j_q == 2'd2 ? 2'd0 : j_q + 2'd1) : j_q;
      i_d = (k_q == 2'd2 && j_q == 2'd2) ? (i_q == 2'd2 ? 2'd0 : i_q + 2'd1) : i_q;
      drain_d = k_q == 2'd2 && j_q == 2'd2 && i_q == 2'd2;
    end
    if (sum_valid) begin
      c_d[int'(e_q)*DW +: DW] = sum;
      e_d = e_q + 4'd1;
      state_d = e_q == 4'd8 ? DONE : state_q;
    end
    if (state_q == DONE && bus.out_ready) state_d = IDLE;
  end
  // state, counter and matrix registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      e_q <= '0;
      drain_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      e_q <= e_d;
      drain_q <= drain_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end
endmodule

// File: tb/tb_mmult3x3_seq.sv
// tb_mmult3x3_seq: directed checks of mmult3x3_seq (define MMULT3X3_SEQ_PIPE_EN for the pipelined build)
module tb_mmult3x3_seq;
  localparam int W = 18;
  localparam int MW = 9 * W;
`ifdef MMULT3X3_SEQ_PIPE_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 27;
`endif
  localparam int PER = LAT + 2;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_err = 0;
  mmult3x3_seq_if #(.DW(W)) bus();
  mmult3x3_seq #(.DW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
    logic [MW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*W +: W] = v;
    return r;
  endfunction
  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*W +: W] = (e % 4 == 0) ? 18'd1 : 18'd0;
    return r;
  endfunction
  function automatic logic [MW-1:0] seq9();
    logic [MW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*W +: W] = W'(e + 1);
    return r;
  endfunction
  function automatic logic [MW-1:0] rowsum();
    logic [MW-1:0] r;
    for (int e = 0; e < 9; e++) r[e*W +: W] = (e < 3) ? 18'd6 : (e < 6) ? 18'd15 : 18'd24;
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b);
    bus.ai = a;
    bus.bi = b;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, MW'(bus.in_ready), MW'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(input string tag, output logic busy_ok);
    int n;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 100) begin
      busy_ok &= bus.busy & ~bus.in_ready;
      tick();
      n++;
    end
    busy_ok &= bus.busy & ~bus.in_ready;
    chk({tag, "_latency"}, MW'(n), MW'(LAT));
  endtask
  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ready_after"}, MW'(bus.in_ready), MW'(1));
    chk({tag, "_valid_after"}, MW'(bus.out_valid), MW'(0));
  endtask
  initial begin
    logic ok;
    logic [MW-1:0] hold;
    logic [MW-1:0] outs [2];
    int t_acc [2];
    int na, no;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ai = '0;
    bus.bi = '0;
    #12;
    chk("rst_in_ready", MW'(bus.in_ready), MW'(1));
    chk("rst_out_valid", MW'(bus.out_valid), MW'(0));
    chk("rst_busy", MW'(bus.busy), MW'(0));
    chk("rst_co", bus.co, '0);
    rst_n = 1'b1;
    tick();
    send("id", ident(), seq9());
    wait_out("id", ok);
    chk("id_co", bus.co, seq9());
    ack("id");
    send("ones", fill(18'd1), fill(18'd1));
    wait_out("ones", ok);
    chk("ones_busy", MW'(ok), MW'(1));
    chk("ones_co", bus.co, fill(18'd3));
    ack("ones");
    send("wrap", fill(18'h3FFFF), fill(18'h3FFFF));
    wait_out("wrap", ok);
    chk("wrap_co", bus.co, fill(18'd3));
    ack("wrap");
    send("bp", seq9(), fill(18'd1));
    wait_out("bp", ok);
    hold = bus.co;
    ok = 1'b1;
    repeat (10) begin
      ok &= bus.out_valid & ~bus.in_ready & (bus.co === hold);
      tick();
    end
    ok &= bus.out_valid & ~bus.in_ready & (bus.co === hold);
    chk("bp_hold", MW'(ok), MW'(1));
    chk("bp_co", bus.co, rowsum());
    ack("bp");
    send("rst", ident(), seq9());
    repeat (9) tick();
    chk("rst_mid_busy_before", MW'(bus.busy), MW'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", MW'(bus.out_valid), MW'(0));
    chk("rst_mid_co", bus.co, '0);
    chk("rst_mid_in_ready", MW'(bus.in_ready), MW'(1));
    chk("rst_mid_busy", MW'(bus.busy), MW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    send("rst2", ident(), seq9());
    wait_out("rst2", ok);
    chk("rst2_co", bus.co, seq9());
    ack("rst2");
    bus.out_ready = 1'b1;
    bus.ai = ident();
    bus.bi = seq9();
    bus.in_valid = 1'b1;
    na = 0;
    no = 0;
    t_acc[0] = 0;
    t_acc[1] = 0;
    outs[0] = '0;
    outs[1] = '0;
    for (int c = 0; c < 200 && no < 2; c++) begin
      if (na == 1) begin
        bus.ai = seq9();
        bus.bi = fill(18'd1);
      end
      if (bus.in_valid && bus.in_ready && na < 2) begin
        t_acc[na] = c;
        na++;
      end
      if (bus.out_valid && bus.out_ready) begin
        outs[no] = bus.co;
        no++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_outputs", MW'(no), MW'(2));
    chk("b2b_period", MW'(t_acc[1] - t_acc[0]), MW'(PER));
    chk("b2b_co0", outs[0], seq9());
    chk("b2b_co1", outs[1], rowsum());
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mmult3x3_seq.md
Name: mmult3x3_seq

Overview:
- Sequenced 3x3 matrix multiplier computing C = A*B with one shared multiplier and one accumulator, instead of 27 parallel multipliers.
- Matrices enter and leave as flat packed buses, using a valid/ready handshake on each side.
- Intended as the area-reduced, DSP-light variant for benchmark designs where multiplier count dominates.

Parameters:
- DW, 18, element width in bits for A, B and C.
- N, 3, matrix dimension. Fixed at 3; any other value is illegal and must trigger an elaboration error.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  A/B operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- ai  in  9*DW  matrix A, packed.
- bi  in  9*DW  matrix B, packed.
- out_valid  out  1  result C valid.
- out_ready  in  1  consumer accepts C.
- co  out  9*DW  matrix C, packed.
- busy  out  1  high in MAC or DONE.

Behaviour:
- Packing: element (i,j), 1-based, occupies bits [((i-1)*3+(j-1))*DW +: DW]. This applies to ai, bi and co.
- Reset values: in_ready=1, out_valid=0, busy=0, co=0. Internal A/B registers, accumulator and counters are also 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch ai/bi, clear the accumulator, set i=j=k=0, go to MAC.
  - MAC: one product A[i][k]*B[k][j] per cycle, k innermost, then j, then i (row-major over C).
    - For k<2: acc <= acc + prod.
    - For k==2: C[i][j] <= acc + prod, then acc <= 0.
    - After (i,j,k)=(2,2,2), go to DONE.
  - DONE: out_valid=1 and co held stable. On out_ready, go to IDLE.
- Arithmetic:
  - Product is formed at 2*DW bits, unsigned.
  - Accumulation and the stored C are the low DW bits, i.e. modulo 2^DW. There is no saturation and no overflow flag.
- Latency:
  - Acceptance edge E0; MAC edges E1..E27.
  - out_valid is first high in the cycle after E27, i.e. 27 cycles after acceptance.
- Handshake:
  - in_ready is low in MAC and DONE; ai/bi are ignored there.
  - Output is not bypassed: after the out_valid&&out_ready edge, in_ready is high from the next cycle. Minimum period between accepts is 29 cycles.
  - out_valid does not drop without out_ready; co does not change while out_valid is high.
- Register updates: co is updated element-by-element during MAC and only presented as valid in DONE. Consumers must ignore co when out_valid=0.
- Reset mid-operation: everything returns to reset values immediately, the in-flight result is discarded, and in_ready is high while rst_n is low.
- Simultaneous in_valid and out_ready in DONE: only the output transfer completes. The input is accepted in the following IDLE cycle if still valid.

Optional Feature:
- Macro: MMULT3X3_SEQ_PIPE_EN.
- Defined:
  - A register stage is inserted between multiplier and adder; the accumulator uses the product from the previous cycle.
  - The MAC state gains one drain cycle.
  - Latency becomes 28 cycles from acceptance to out_valid.
  - Minimum accept period becomes 30 cycles.
  - Results are identical to the undefined case.
- Undefined: combinational multiply-add as described above.

Decomposition:
- Shared package mmult_pkg holds:
  - constant N=3 and default DW=18;
  - state typedef {IDLE, MAC, DONE};
  - index helper function returning the bit offset ((i*3)+j)*DW for 0-based i, j.
- One sub-module, mmult_mac: multiplier, optional pipeline register and accumulator, with inputs a, b, clr, last and outputs sum, sum_valid.
- The top level holds the FSM, i/j/k counters, operand registers and C registers.

Test Plan:
- Identity test: A=identity, B=1..9 row-major, in_valid one cycle.
  - Expect co = B exactly.
  - Expect out_valid first high 27 cycles after acceptance (28 with PIPE_EN).
- All-ones test: A=B=all 1.
  - Expect every C element = 3.
  - Expect busy high throughout MAC and DONE.
- Wrap test: A=B=all 0x3FFFF, DW=18.
  - Each product is 1 mod 2^18, so every C element = 0x00003.
- Backpressure: out_ready held low 10 cycles after out_valid rises.
  - co stable, out_valid high, in_ready low throughout.
  - After the out_ready pulse, in_ready is high the next cycle.
- Reset mid-operation: assert rst_n low at MAC cycle 10.
  - Immediately out_valid=0, co=0, in_ready=1, busy=0.
  - A new pair A=identity, B=1..9 then yields C=1..9.
- Back-to-back: in_valid held high with two different pairs and out_ready tied high.
  - Two correct results, with accepts 29 cycles apart (30 with PIPE_EN).
